// File: rtl/fetch_queue.sv
// Instruction prefetch queue between the imem handshake port and ID.
// Optional same-cycle bypass of an empty queue: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int Width = 32,
   parameter int Depth = 4,
   parameter logic [Width-1:0] ResetPc = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect,
   input  logic [Width-1:0]           redirect_pc,
   output logic                       mem_valid,
   output logic [Width-1:0]           mem_addr,
   input  logic                       mem_ready,
   input  logic                       mem_done,
   input  logic [Width-1:0]           mem_data,
   output logic                       out_valid,
   output logic [Width-1:0]           out_pc,
   output logic [Width-1:0]           out_insn,
   input  logic                       out_ready,
   output logic                       stallreq,
   output logic [$clog2(Depth+1)-1:0] count
);

   localparam int PW = $clog2(Depth);
   localparam int CW = $clog2(Depth+1);
   localparam logic [CW-1:0] Full = CW'(Depth);
   localparam logic [Width-1:0] Nop = Width'(32'h0000_0013);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] REQ   = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [Width-1:0] fetch_pc;
   logic [Width-1:0] req_pc;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nx;
   logic [Width-1:0] pc_q [Depth];
   logic [Width-1:0] insn_q [Depth];

   logic has;
   logic done_ok;
   logic byp;
   logic enq;
   logic deq;
   logic accept;

   assign has     = cnt != '0;
   assign done_ok = (state == WAIT) && mem_done && !redirect;
   assign accept  = (state == REQ) && mem_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign byp = !has && done_ok;
`else
   assign byp = 1'b0;
`endif

   // A bypassed response taken by the consumer never occupies a slot
   assign enq = done_ok && !(byp && out_ready);
   assign deq = has && out_ready;

   always_comb begin
      cnt_nx = cnt;
      if (enq && !deq)
         cnt_nx = cnt + 1'b1;
      else if (!enq && deq)
         cnt_nx = cnt - 1'b1;
   end

   // A response that coincides with the redirect is the old one
   always_comb begin
      state_nx = state;
      if (redirect) begin
         unique case (state)
            IDLE:    state_nx = REQ;
            REQ:     state_nx = mem_ready ? DRAIN : REQ;
            WAIT,
            DRAIN:   state_nx = mem_done ? REQ : DRAIN;
            default: state_nx = IDLE;
         endcase
      end else begin
         unique case (state)
            IDLE:    if (cnt < Full) state_nx = REQ;
            REQ:     if (mem_ready) state_nx = WAIT;
            WAIT:    if (mem_done) state_nx = (cnt_nx < Full) ? REQ : IDLE;
            DRAIN:   if (mem_done) state_nx = REQ;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         fetch_pc <= ResetPc;
         req_pc   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
      end else begin
         state <= state_nx;
         if (accept)
            req_pc <= fetch_pc;
         if (redirect) begin
            fetch_pc <= redirect_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + Width'(4);
            if (enq)
               wr_ptr <= wr_ptr + 1'b1;
            if (deq)
               rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt_nx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         pc_q[wr_ptr]   <= req_pc;
         insn_q[wr_ptr] <= mem_data;
      end
   end

   assign mem_valid = state == REQ;
   assign mem_addr  = fetch_pc;
   assign out_valid = has || byp;
   assign stallreq  = !out_valid;
   assign count     = cnt;

   always_comb begin
      out_pc   = '0;
      out_insn = Nop;
      if (has) begin
         out_pc   = pc_q[rd_ptr];
         out_insn = insn_q[rd_ptr];
      end else if (byp) begin
         out_pc   = req_pc;
         out_insn = mem_data;
      end
   end

endmodule
